// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: FSM states, grant
// encoding, default widths and the address range helper.
package dmem_pkg;

  localparam int ADDR_WIDTH_DEF   = 5;
  localparam int DATA_WIDTH_DEF   = 32;
  localparam int DBG_MAX_WAIT_DEF = 8;
  localparam int WAIT_CNT_WIDTH   = 8;

  typedef enum logic {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE  = 2'd0,
    GNT_CPU   = 2'd1,
    GNT_DBG   = 2'd2,
    GNT_SWEEP = 2'd3
  } grant_t;

  // Any set bit above the word index means the byte address is beyond the RAM.
  function automatic logic addr_out_of_range(input logic [31:0] byte_addr,
                                             input int          addr_width);
    logic [31:0] upper_s;
    upper_s = byte_addr >> (addr_width + 2);
    return (upper_s != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Per-cycle grant for the single RAM port: CPU first, debug forced after a
// bounded wait, sweep owns the port while the controller is not running.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   run_en,
  input  logic   cpu_valid,
  input  logic   dbg_req,
  output grant_t grant,
  output logic   force_dbg
);

  logic [WAIT_CNT_WIDTH-1:0] wait_cnt_r;
  grant_t                    grant_s;
  logic                      force_s;

  // Priority grant: forced debug, then CPU, then debug, else idle.
  always_comb begin
    grant_s = GNT_NONE;
    force_s = 1'b0;
    if (!run_en) begin
      grant_s = GNT_SWEEP;
    end else if (dbg_req && (wait_cnt_r == WAIT_CNT_WIDTH'(DBG_MAX_WAIT))) begin
      grant_s = GNT_DBG;
      force_s = 1'b1;
    end else if (cpu_valid) begin
      grant_s = GNT_CPU;
    end else if (dbg_req) begin
      grant_s = GNT_DBG;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Consecutive cycles a debug request has been left waiting.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_r <= '0;
    end else if (!run_en || !dbg_req || (grant_s == GNT_DBG)) begin
      wait_cnt_r <= '0;
    end else begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end
  end

  assign grant     = grant_s;
  assign force_dbg = force_s;

endmodule

// File: rtl/data_memory_controller.sv
// Front end of the data RAM: CPU/debug port arbitration, byte-to-word mapping,
// range check and read steering. Define CLEAR_ON_RESET_EN for the post-reset zero sweep.
module data_memory_controller
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int DBG_MAX_WAIT = DBG_MAX_WAIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cpu_valid,
  input  logic                  cpu_write,
  input  logic [31:0]           cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  output logic                  cpu_stall,
  output logic                  cpu_read_valid,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_addr_error,
  input  logic                  dbg_req,
  input  logic                  dbg_write,
  input  logic [ADDR_WIDTH-1:0] dbg_address,
  input  logic [DATA_WIDTH-1:0] dbg_write_data,
  output logic                  dbg_ack,
  output logic [DATA_WIDTH-1:0] dbg_read_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_input_data,
  output logic                  ram_write_enabled,
  input  logic [DATA_WIDTH-1:0] ram_output_data
);

  grant_t                grant_s;
  grant_t                rd_owner_r;
  logic                  force_s;
  logic                  run_s;
  logic                  cpu_oor_s;
  logic                  cpu_rd_oor_r;
  logic                  cpu_addr_error_r;
  logic                  dbg_ack_r;
  logic [ADDR_WIDTH-1:0] cpu_index_s;
  logic [ADDR_WIDTH-1:0] sweep_addr_s;
  logic [ADDR_WIDTH-1:0] last_addr_r;
  logic [DATA_WIDTH-1:0] cpu_rdata_s;
  logic [DATA_WIDTH-1:0] dbg_rdata_s;
  logic [DATA_WIDTH-1:0] cpu_hold_r;
  logic [DATA_WIDTH-1:0] dbg_hold_r;

`ifdef CLEAR_ON_RESET_EN
  state_t                state_r;
  logic [ADDR_WIDTH-1:0] sweep_cnt_r;

  // Sweep FSM: one zero write per cycle over every word, then run.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r     <= ST_SWEEP;
      sweep_cnt_r <= '0;
    end else begin
      case (state_r)
        ST_SWEEP: begin
          if (sweep_cnt_r == '1) begin
            state_r     <= ST_RUN;
            sweep_cnt_r <= '0;
          end else begin
            sweep_cnt_r <= sweep_cnt_r + ADDR_WIDTH'(1);
          end
        end
        ST_RUN: begin
          state_r <= ST_RUN;
        end
        default: begin
          state_r     <= ST_SWEEP;
          sweep_cnt_r <= '0;
        end
      endcase
    end
  end

  assign run_s        = (state_r == ST_RUN);
  assign sweep_addr_s = sweep_cnt_r;
`else
  assign run_s        = 1'b1;
  assign sweep_addr_s = '0;
`endif

  assign busy      = !run_s;
  assign cpu_stall = !run_s || force_s;

  assign cpu_index_s = cpu_address[ADDR_WIDTH+1:2];
  assign cpu_oor_s   = addr_out_of_range(cpu_address, ADDR_WIDTH);

  dmem_arbiter #(
    .DBG_MAX_WAIT (DBG_MAX_WAIT)
  ) u_arbiter (
    .clock     (clock),
    .reset     (reset),
    .run_en    (run_s),
    .cpu_valid (cpu_valid),
    .dbg_req   (dbg_req),
    .grant     (grant_s),
    .force_dbg (force_s)
  );

  // RAM pin mux for the current owner; an out-of-range CPU store never writes.
  always_comb begin
    ram_address       = last_addr_r;
    ram_input_data    = '0;
    ram_write_enabled = 1'b0;
    case (grant_s)
      GNT_SWEEP: begin
        ram_address       = sweep_addr_s;
        ram_input_data    = '0;
        ram_write_enabled = 1'b1;
      end
      GNT_CPU: begin
        ram_address       = cpu_index_s;
        ram_input_data    = cpu_write_data;
        ram_write_enabled = cpu_write && !cpu_oor_s;
      end
      GNT_DBG: begin
        ram_address       = dbg_address;
        ram_input_data    = dbg_write_data;
        ram_write_enabled = dbg_write;
      end
      default: begin
        ram_address       = last_addr_r;
        ram_input_data    = '0;
        ram_write_enabled = 1'b0;
      end
    endcase
  end

  // Read-slot owner tag, acks, error pulse and the held read-data values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_owner_r       <= GNT_NONE;
      cpu_rd_oor_r     <= 1'b0;
      cpu_addr_error_r <= 1'b0;
      dbg_ack_r        <= 1'b0;
      last_addr_r      <= '0;
      cpu_hold_r       <= '0;
      dbg_hold_r       <= '0;
    end else begin
      if ((grant_s == GNT_CPU) && !cpu_write) begin
        rd_owner_r <= GNT_CPU;
      end else if ((grant_s == GNT_DBG) && !dbg_write) begin
        rd_owner_r <= GNT_DBG;
      end else begin
        rd_owner_r <= GNT_NONE;
      end
      cpu_rd_oor_r     <= cpu_oor_s;
      cpu_addr_error_r <= (grant_s == GNT_CPU) && cpu_oor_s;
      dbg_ack_r        <= (grant_s == GNT_DBG);
      last_addr_r      <= ram_address;
      cpu_hold_r       <= cpu_rdata_s;
      dbg_hold_r       <= dbg_rdata_s;
    end
  end

  // Steer the RAM output to whichever port owned last cycle's read.
  always_comb begin
    cpu_rdata_s = cpu_hold_r;
    dbg_rdata_s = dbg_hold_r;
    if (rd_owner_r == GNT_CPU) begin
      cpu_rdata_s = cpu_rd_oor_r ? '0 : ram_output_data;
    end else if (rd_owner_r == GNT_DBG) begin
      dbg_rdata_s = ram_output_data;
    end else begin
      cpu_rdata_s = cpu_hold_r;
      dbg_rdata_s = dbg_hold_r;
    end
  end

  assign cpu_read_valid = (rd_owner_r == GNT_CPU);
  assign cpu_read_data  = cpu_rdata_s;
  assign cpu_addr_error = cpu_addr_error_r;
  assign dbg_ack        = dbg_ack_r;
  assign dbg_read_data  = dbg_rdata_s;

endmodule
